instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
//------------------------------------------------------------------------------
// instr_loader
//
// Loads a length-prefixed instruction image from a valid/ready byte stream into
// an instruction memory, then releases the cores with a one-cycle pulse.
//
// Stream format: N, I0 .. I(N-1) [, C]
//   N      instruction count (1..256-BASE_ADDR; 0 or an overflowing count errors)
//   Ik     instruction byte, written to BASE_ADDR+k one cycle after acceptance
//   C      checksum byte (sum of Ik mod 256), only when INSTR_LOADER_CHECKSUM_EN
//          is defined; it is compared, never written
// The last instruction byte must equal END_OP or the load ends in error.
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//   defined   : CSUM state and running-sum register present
//   undefined : valid last byte goes straight to DONE
//
// Parameters
//   BASE_ADDR  first instruction-memory address written
//   END_OP     opcode required as the last instruction byte
//
// Ports
//   clock          in   single clock, posedge
//   reset_n        in   asynchronous active-low reset
//   start          in   one-cycle pulse, arms a load (honoured in IDLE only)
//   in_valid       in   byte-stream valid
//   in_data[7:0]   in   byte-stream data
//   in_ready       out  high in LEN, LOAD, CSUM
//   write_en_file  out  instruction-memory write strobe
//   addr_file[7:0] out  instruction-memory write address (holds between writes)
//   instr_file[7:0]out  instruction-memory write data (holds between writes)
//   busy           out  high whenever the FSM is not IDLE
//   load_done      out  one-cycle pulse on a successful load
//   load_error     out  sticky error flag, cleared by the next accepted start
//   core_start     out  one-cycle pulse coincident with load_done
//------------------------------------------------------------------------------
module instr_loader #(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter logic [7:0] END_OP    = 8'd38
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       write_en_file,
    output logic [7:0] addr_file,
    output logic [7:0] instr_file,
    output logic       busy,
    output logic       load_done,
    output logic       load_error,
    output logic       core_start
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LOAD = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LOAD = 3'd2,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;
`endif

    state_t     state;
    state_t     next_state;

    logic       accept;
    logic       len_bad;
    logic       last_byte;

    logic [7:0] count;      // N, latched in LEN
    logic [7:0] index;      // k, position of the next instruction byte
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] sum;        // running instruction-byte sum mod 256
`endif

    assign accept = in_valid & in_ready;

    // Ten bits so that BASE_ADDR+N can exceed 256 without wrapping.
    assign len_bad   = (in_data == 8'd0) ||
                       (({2'b00, BASE_ADDR} + {2'b00, in_data}) > 10'd256);
    assign last_byte = (index == (count - 8'd1));

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    //--------------------------------------------------------------------------
    // Next state and state-decoded outputs
    //--------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        load_done  = 1'b0;
        core_start = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = LEN;
                end
            end

            LEN: begin
                in_ready = 1'b1;
                if (accept) begin
                    next_state = len_bad ? ERR : LOAD;
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                if (accept && last_byte) begin
                    if (in_data != END_OP) begin
                        next_state = ERR;
                    end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end
                end
            end

`ifdef INSTR_LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    next_state = (in_data == sum) ? DONE : ERR;
                end
            end
`endif

            DONE: begin
                load_done  = 1'b1;
                core_start = 1'b1;
                next_state = IDLE;
            end

            ERR: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Write port, byte index and sticky error
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index         <= 8'd0;
            write_en_file <= 1'b0;
            addr_file     <= 8'd0;
            instr_file    <= 8'd0;
            load_error    <= 1'b0;
        end else begin
            write_en_file <= 1'b0;

            if (state == IDLE && start) begin
                load_error <= 1'b0;
            end
            // Set on entry so the flag is already high during the ERR cycle.
            if (next_state == ERR) begin
                load_error <= 1'b1;
            end

            if (state == LEN && accept) begin
                index <= 8'd0;
            end

            if (state == LOAD && accept) begin
                write_en_file <= 1'b1;
                addr_file     <= BASE_ADDR + index;
                instr_file    <= in_data;
                index         <= index + 8'd1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Count and checksum (data only, no reset needed)
    //--------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (state == LEN && accept) begin
            count <= in_data;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (state == LEN && accept) begin
            sum <= 8'd0;
        end else if (state == LOAD && accept) begin
            sum <= sum + in_data;
        end
`endif
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam logic [7:0] BASE = 8'd0;
    localparam logic [7:0] ENDB = 8'd38;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [3:0]  len;
        logic [63:0] b;      // byte j at b[8*j +: 8]
        logic [1:0]  stall;  // 0 none, 1 toggle, 2 random
        logic        done;
        logic        err;
        logic [3:0]  nw;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       write_en_file;
    logic [7:0] addr_file;
    logic [7:0] instr_file;
    logic       busy;
    logic       load_done;
    logic       load_error;
    logic       core_start;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] wr_q[$];
    int          wcyc_q[$];
    int          acc_q[$];
    int          done_cnt;
    int          core_cnt;
    logic [7:0]  hold_a;
    logic [7:0]  hold_d;

    logic [15:0] exp_w[$];
    int          exp_cons;
    int          exp_nload;
    int          exp_done;
    int          exp_err;

    vec_t vt[8];
    int   nvec;

    instr_loader #(.BASE_ADDR(BASE), .END_OP(ENDB)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .write_en_file(write_en_file),
        .addr_file(addr_file),
        .instr_file(instr_file),
        .busy(busy),
        .load_done(load_done),
        .load_error(load_error),
        .core_start(core_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, longint got, longint expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endfunction

    // Observe the write port and pulses away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_a = 8'd0;
            hold_d = 8'd0;
        end else begin
            if (write_en_file) begin
                wr_q.push_back({addr_file, instr_file});
                wcyc_q.push_back(cyc);
                hold_a = addr_file;
                hold_d = instr_file;
            end else begin
                chk("hold_addr", addr_file, hold_a);
                chk("hold_instr", instr_file, hold_d);
            end
            if (load_done) done_cnt++;
            if (core_start) core_cnt++;
            chk("core_start_eq_done", core_start, load_done);
        end
    end

    // Reference: what a load of stream s should produce, from the stream rules.
    function automatic void model(input bq_t s);
        int n;
        int sum;
        exp_w.delete();
        exp_done  = 0;
        exp_err   = 0;
        exp_cons  = 1;
        exp_nload = 0;
        n = int'(s[0]);
        if (n == 0 || int'(BASE) + n > 256) begin
            exp_err = 1;
            return;
        end
        sum = 0;
        for (int k = 0; k < n; k++) begin
            exp_w.push_back({8'(int'(BASE) + k), s[1+k]});
            sum = (sum + int'(s[1+k])) % 256;
        end
        exp_cons  = 1 + n;
        exp_nload = n;
        if (s[n] != ENDB) begin
            exp_err = 1;
            return;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        exp_cons = exp_cons + 1;
        if (int'(s[n+1]) != sum) exp_err = 1;
        else exp_done = 1;
`else
        exp_done = 1;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b, input int stall, input bit poke,
                             inout bit ph, output bit ok);
        bit v;
        bit acc;
        int tries;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 64) begin
            case (stall)
                0: v = 1'b1;
                1: begin v = ph; ph = !ph; end
                default: v = ($urandom % 3) != 0;
            endcase
            in_valid = v;
            in_data  = v ? b : 8'($urandom);
            start    = poke;
            @(negedge clock);
            acc = v && in_ready;
            @(posedge clock);
            #1;
            start = 1'b0;
            if (acc) ok = 1'b1;
            tries++;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Runs one load; t_done < 0 means no table expectation to check as well.
    task automatic do_load(input bq_t s, input int stall, input bit poke,
                           input int t_done, input int t_err, input int t_nw);
        bit ph;
        bit ok;
        model(s);
        wr_q.delete();
        wcyc_q.delete();
        acc_q.delete();
        done_cnt = 0;
        core_cnt = 0;
        ph = 1'b1;
        pulse_start();
        @(negedge clock);
        chk("err_clear_on_start", load_error, 0);
        chk("busy_after_start", busy, 1);
        @(posedge clock);
        #1;
        for (int i = 0; i < exp_cons; i++) begin
            send_byte(s[i], stall, poke && (i == 2), ph, ok);
            if (!ok) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            if (i >= 1 && i <= exp_nload) acc_q.push_back(cyc);
        end
        for (int k = 0; k < 20 && busy; k++) @(negedge clock);
        chk("idle_reached", busy, 0);
        @(negedge clock);
        chk("n_writes", wr_q.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++) begin
            chk("write_addr_data", wr_q[k], exp_w[k]);
            if (k < acc_q.size()) chk("write_latency", wcyc_q[k], acc_q[k]);
        end
        chk("load_done_pulses", done_cnt, exp_done);
        chk("core_start_pulses", core_cnt, exp_done);
        chk("load_error", load_error, exp_err);
        if (t_done >= 0) begin
            chk("tbl_done", done_cnt, t_done);
            chk("tbl_err", load_error, t_err);
            chk("tbl_nwrites", wr_q.size(), t_nw);
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_write_en"}, write_en_file, 0);
        chk({tag, "_addr"}, addr_file, 0);
        chk({tag, "_instr"}, instr_file, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_load_error"}, load_error, 0);
        chk({tag, "_core_start"}, core_start, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s;
        bit  ph;
        bit  ok;
        int  n;
        int  sum;
        logic [7:0] bb;

`ifdef INSTR_LOADER_CHECKSUM_EN
        vt[0] = '{len: 4'd5, b: 64'h0000_0053_2624_0903, stall: 2'd0, done: 1'b1, err: 1'b0, nw: 4'd3};
        vt[1] = '{len: 4'd5, b: 64'h0000_0053_2624_0903, stall: 2'd1, done: 1'b1, err: 1'b0, nw: 4'd3};
        vt[2] = '{len: 4'd1, b: 64'h0000_0000_0000_0000, stall: 2'd0, done: 1'b0, err: 1'b1, nw: 4'd0};
        vt[3] = '{len: 4'd3, b: 64'h0000_0000_001B_0902, stall: 2'd0, done: 1'b0, err: 1'b1, nw: 4'd2};
        vt[4] = '{len: 4'd3, b: 64'h0000_0000_0027_2601, stall: 2'd0, done: 1'b0, err: 1'b1, nw: 4'd1};
        vt[5] = '{len: 4'd3, b: 64'h0000_0000_0026_2601, stall: 2'd2, done: 1'b1, err: 1'b0, nw: 4'd1};
        nvec = 6;
`else
        vt[0] = '{len: 4'd4, b: 64'h0000_0000_2624_0903, stall: 2'd0, done: 1'b1, err: 1'b0, nw: 4'd3};
        vt[1] = '{len: 4'd4, b: 64'h0000_0000_2624_0903, stall: 2'd1, done: 1'b1, err: 1'b0, nw: 4'd3};
        vt[2] = '{len: 4'd1, b: 64'h0000_0000_0000_0000, stall: 2'd0, done: 1'b0, err: 1'b1, nw: 4'd0};
        vt[3] = '{len: 4'd3, b: 64'h0000_0000_001B_0902, stall: 2'd0, done: 1'b0, err: 1'b1, nw: 4'd2};
        vt[4] = '{len: 4'd2, b: 64'h0000_0000_0000_2601, stall: 2'd2, done: 1'b1, err: 1'b0, nw: 4'd1};
        nvec = 5;
`endif

        // Power-on reset
        #3;
        check_all_zero("por");
        #19 reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("post_release");

        // Directed table
        for (int i = 0; i < nvec; i++) begin
            s.delete();
            for (int j = 0; j < int'(vt[i].len); j++) s.push_back(vt[i].b[8*j +: 8]);
            do_load(s, int'(vt[i].stall), 1'b0, int'(vt[i].done), int'(vt[i].err), int'(vt[i].nw));
        end

        // Reset in the middle of a 5-byte load, after the 2nd instruction byte
        wr_q.delete();
        pulse_start();
        ph = 1'b1;
        send_byte(8'd5, 0, 1'b0, ph, ok);
        chk("rst_seq_len_acc", ok, 1);
        send_byte(8'h11, 0, 1'b0, ph, ok);
        chk("rst_seq_b1_acc", ok, 1);
        send_byte(8'h22, 0, 1'b0, ph, ok);
        chk("rst_seq_b2_acc", ok, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        in_valid = 1'b1;
        in_data  = 8'h33;
        start    = 1'b1;
        repeat (3) @(posedge clock);
        #1 start = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("after_reset_busy", busy, 0);
        chk("after_reset_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clock);
        chk("rst_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) chk("rst_first_write", wr_q[0], {BASE, 8'h11});

        // Fresh load after reset, with start pulsed while busy
        s.delete();
        s.push_back(8'd3);
        s.push_back(8'h41);
        s.push_back(8'h42);
        s.push_back(ENDB);
`ifdef INSTR_LOADER_CHECKSUM_EN
        s.push_back(8'(8'h41 + 8'h42 + ENDB));
`endif
        do_load(s, 0, 1'b1, 1, 0, 3);

        // Randomized loads against the reference
        for (int r = 0; r < 30; r++) begin
            s.delete();
            n = (($urandom % 10) == 0) ? 0 : int'($urandom_range(1, 12));
            s.push_back(8'(n));
            sum = 0;
            for (int k = 0; k < n; k++) begin
                bb = 8'($urandom);
                if (k == n - 1 && ($urandom % 4) != 0) bb = ENDB;
                s.push_back(bb);
                sum = (sum + int'(bb)) % 256;
            end
            if (($urandom % 4) != 0) s.push_back(8'(sum));
            else s.push_back(8'(sum + 1 + int'($urandom % 255)));
            do_load(s, int'($urandom % 3), 1'(($urandom % 2)), -1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
